// File: rtl/scan_sequencer.sv
`timescale 1ns/1ps
// Shot scheduler for the ultrasonic transmit path: sequences pulse, delay and
// acquisition gate per shot over all enabled channels, gated by the capture buffer.
module scan_sequencer #(
   parameter int NCH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   cont,
   input  logic [19:0]            cfg_cycle,
   input  logic [11:0]            cfg_pulse,
   input  logic [15:0]            cfg_delay,
   input  logic [15:0]            cfg_gate,
   input  logic [7:0]             cfg_shots,
   input  logic [NCH-1:0]         cfg_mask,
   input  logic                   buf_ready,
   output logic                   busy,
   output logic                   tx_pulse,
   output logic [$clog2(NCH)-1:0] tx_ch,
   output logic                   gate,
   output logic                   shot_start,
   output logic                   frame_done,
   output logic                   overrun
);
   localparam int CW = $clog2(NCH);
   localparam logic [20:0] PCNT_MAX = '1;

   typedef enum logic [2:0] {IDLE, ARM, FIRE, DELAY, GATE, HOLD} state_t;

   state_t         state_reg, state_next;

   // shadow copies of the configuration, frozen for the whole scan
   logic [19:0]    cycle_reg;
   logic [15:0]    pulse_reg;
   logic [15:0]    delay_reg;
   logic [15:0]    gate_len_reg;
   logic [7:0]     shots_reg;
   logic [NCH-1:0] mask_reg;
   logic           cont_reg;
   logic           load_cfg;

   logic [20:0]    pcnt_reg, pcnt_next, pcnt_inc;
   logic [15:0]    seg_reg, seg_next;
   logic [7:0]     shot_cnt_reg, shot_cnt_next;
   logic [CW-1:0]  ch_reg, ch_next;
   logic           overrun_reg, overrun_next;
   logic           frame_done_next;
   logic           shot_end;
   logic           start_ok;

   logic           busy_reg, tx_pulse_reg, gate_reg, shot_start_reg, frame_done_reg;

   logic [NCH-1:0] above_mask;
   logic           has_higher;
   logic [CW-1:0]  higher_ch;
   logic [CW-1:0]  first_cfg_ch;
   logic [CW-1:0]  first_shadow_ch;

   function automatic logic [CW-1:0] lowest_bit(input logic [NCH-1:0] m);
      logic [CW-1:0] idx;
      idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (m[i]) idx = CW'(i);
      end
      return idx;
   endfunction

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_above
         assign above_mask[gi] = mask_reg[gi] && (CW'(gi) > ch_reg);
      end
   endgenerate

   assign has_higher      = |above_mask;
   assign higher_ch       = lowest_bit(above_mask);
   assign first_cfg_ch    = lowest_bit(cfg_mask);
   assign first_shadow_ch = lowest_bit(mask_reg);

   assign start_ok = start && !abort && (state_reg == IDLE) && (|cfg_mask);
   assign pcnt_inc = (pcnt_reg == PCNT_MAX) ? pcnt_reg : pcnt_reg + 21'd1;

   always_comb begin
      state_next      = state_reg;
      pcnt_next       = pcnt_reg;
      seg_next        = seg_reg;
      shot_cnt_next   = shot_cnt_reg;
      ch_next         = ch_reg;
      overrun_next    = overrun_reg;
      frame_done_next = 1'b0;
      load_cfg        = 1'b0;
      shot_end        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start_ok) begin
               state_next    = ARM;
               ch_next       = first_cfg_ch;
               shot_cnt_next = '0;
               overrun_next  = 1'b0;
               load_cfg      = 1'b1;
            end
         end
         ARM: begin
            if (buf_ready) begin
               state_next = FIRE;
               pcnt_next  = 21'd1;
               seg_next   = 16'd1;
            end
         end
         FIRE: begin
            pcnt_next = pcnt_inc;
            if (seg_reg >= pulse_reg) begin
               state_next = (delay_reg == 16'd0) ? GATE : DELAY;
               seg_next   = 16'd1;
            end else begin
               seg_next = seg_reg + 16'd1;
            end
         end
         DELAY: begin
            pcnt_next = pcnt_inc;
            if (seg_reg >= delay_reg) begin
               state_next = GATE;
               seg_next   = 16'd1;
            end else begin
               seg_next = seg_reg + 16'd1;
            end
         end
         GATE: begin
            pcnt_next = pcnt_inc;
            if (seg_reg >= gate_len_reg) begin
               // evaluate the HOLD entry count (pcnt+1) here; a shot that already
               // used up its period skips HOLD entirely and stretches the period
               if (pcnt_reg > {1'b0, cycle_reg}) overrun_next = 1'b1;
               if (pcnt_reg >= {1'b0, cycle_reg}) shot_end = 1'b1;
               else                               state_next = HOLD;
            end else begin
               seg_next = seg_reg + 16'd1;
            end
         end
         HOLD: begin
            pcnt_next = pcnt_inc;
            if (pcnt_reg >= {1'b0, cycle_reg}) shot_end = 1'b1;
         end
         default: state_next = IDLE;
      endcase

      if (shot_end) begin
         if (({1'b0, shot_cnt_reg} + 9'd1) < {1'b0, shots_reg}) begin
            shot_cnt_next = shot_cnt_reg + 8'd1;
            state_next    = ARM;
         end else begin
            shot_cnt_next = '0;
            if (has_higher) begin
               ch_next    = higher_ch;
               state_next = ARM;
            end else begin
               frame_done_next = 1'b1;
               if (cont_reg) begin
                  ch_next    = first_shadow_ch;
                  state_next = ARM;
               end else begin
                  state_next = IDLE;
               end
            end
         end
      end

      // abort overrides everything; channel and overrun flag keep their value
      if (abort) begin
         state_next      = IDLE;
         ch_next         = ch_reg;
         overrun_next    = overrun_reg;
         shot_cnt_next   = shot_cnt_reg;
         frame_done_next = 1'b0;
         load_cfg        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         cycle_reg      <= '0;
         pulse_reg      <= 16'd1;
         delay_reg      <= '0;
         gate_len_reg   <= 16'd1;
         shots_reg      <= 8'd1;
         mask_reg       <= '0;
         cont_reg       <= 1'b0;
         pcnt_reg       <= '0;
         seg_reg        <= '0;
         shot_cnt_reg   <= '0;
         ch_reg         <= '0;
         overrun_reg    <= 1'b0;
         busy_reg       <= 1'b0;
         tx_pulse_reg   <= 1'b0;
         gate_reg       <= 1'b0;
         shot_start_reg <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pcnt_reg       <= pcnt_next;
         seg_reg        <= seg_next;
         shot_cnt_reg   <= shot_cnt_next;
         ch_reg         <= ch_next;
         overrun_reg    <= overrun_next;
         busy_reg       <= (state_next != IDLE);
         tx_pulse_reg   <= (state_next == FIRE);
         gate_reg       <= (state_next == GATE);
         shot_start_reg <= (state_next == FIRE) && (state_reg != FIRE);
         frame_done_reg <= frame_done_next;
         if (load_cfg) begin
            cycle_reg    <= cfg_cycle;
            pulse_reg    <= (cfg_pulse == 12'd0) ? 16'd1 : {4'd0, cfg_pulse};
            delay_reg    <= cfg_delay;
            gate_len_reg <= (cfg_gate == 16'd0) ? 16'd1 : cfg_gate;
            shots_reg    <= (cfg_shots == 8'd0) ? 8'd1 : cfg_shots;
            mask_reg     <= cfg_mask;
            cont_reg     <= cont;
         end
      end
   end

   assign busy       = busy_reg;
   assign tx_pulse   = tx_pulse_reg;
   assign tx_ch      = ch_reg;
   assign gate       = gate_reg;
   assign shot_start = shot_start_reg;
   assign frame_done = frame_done_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
`timescale 1ns/1ps
// Bench for scan_sequencer: table of scan configurations with a per-shot
// scoreboard, plus directed sequences for reset, abort, buffer stall and continuous mode.
module tb_scan_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        cont;
   logic [19:0] cfg_cycle;
   logic [11:0] cfg_pulse;
   logic [15:0] cfg_delay;
   logic [15:0] cfg_gate;
   logic [7:0]  cfg_shots;
   logic [3:0]  cfg_mask;
   logic        buf_ready;
   logic        busy;
   logic        tx_pulse;
   logic [1:0]  tx_ch;
   logic        gate;
   logic        shot_start;
   logic        frame_done;
   logic        overrun;

   scan_sequencer #(.NCH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cont       (cont),
      .cfg_cycle  (cfg_cycle),
      .cfg_pulse  (cfg_pulse),
      .cfg_delay  (cfg_delay),
      .cfg_gate   (cfg_gate),
      .cfg_shots  (cfg_shots),
      .cfg_mask   (cfg_mask),
      .buf_ready  (buf_ready),
      .busy       (busy),
      .tx_pulse   (tx_pulse),
      .tx_ch      (tx_ch),
      .gate       (gate),
      .shot_start (shot_start),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  mask;
      logic [7:0]  shots;
      logic [19:0] cycle;
      logic [11:0] pulse;
      logic [15:0] delay;
      logic [15:0] gate_len;
      int          exp_period;
      int          exp_gate_off;
      int          exp_pulse_w;
      logic        exp_overrun;
   } vec_t;

   typedef struct {
      logic [1:0] ch;
      int         period;
      int         gate_off;
      int         pulse_w;
   } rec_t;

   vec_t tbl [7];
   rec_t sb [$];
   rec_t cur;

   int   tests;
   int   failed;
   int   cyc;
   int   last_shot;
   int   frames;
   bit   mon_en;
   logic pulse_prev;
   logic gate_prev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // one clock step, sampled on the falling edge, with the shot monitor folded in
   task automatic step();
      @(negedge clk);
      cyc++;
      if (mon_en) begin
         if (shot_start) begin
            if (sb.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL unexpected_shot: got shot on ch %0d, expected none (cycle %0d)", tx_ch, cyc);
            end else begin
               cur = sb.pop_front();
               check("shot_ch", tx_ch, cur.ch);
               check("shot_pulse_hi", tx_pulse, 1);
               if (cur.period != 0) check("shot_period", cyc - last_shot, cur.period);
               last_shot = cyc;
            end
         end
         if (!tx_pulse && pulse_prev) check("pulse_width", cyc - last_shot, cur.pulse_w);
         if (gate && !gate_prev) begin
            check("gate_offset", cyc - last_shot, cur.gate_off);
            check("gate_overlap", tx_pulse, 0);
         end
         if (frame_done) frames++;
      end
      pulse_prev = tx_pulse;
      gate_prev  = gate;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int   ns;
      int   nexp;
      int   to;
      rec_t r;
      sb.delete();
      abort     = 1'b0;
      cont      = 1'b0;
      buf_ready = 1'b1;
      cfg_mask  = v.mask;
      cfg_shots = v.shots;
      cfg_cycle = v.cycle;
      cfg_pulse = v.pulse;
      cfg_delay = v.delay;
      cfg_gate  = v.gate_len;
      frames    = 0;
      ns        = (v.shots == 8'd0) ? 1 : int'(v.shots);
      nexp      = 0;
      for (int c = 0; c < 4; c++) begin
         if (v.mask[c]) begin
            for (int s = 0; s < ns; s++) begin
               r.ch       = 2'(c);
               r.period   = (nexp == 0) ? 0 : v.exp_period;
               r.gate_off = v.exp_gate_off;
               r.pulse_w  = v.exp_pulse_w;
               sb.push_back(r);
               nexp++;
            end
         end
      end
      mon_en = 1'b1;
      start  = 1'b1;
      step();
      start = 1'b0;
      check({name, "_busy_up"}, busy, 1);
      // configuration changes after start must not affect the running scan
      cfg_mask  = 4'($urandom);
      cfg_shots = 8'($urandom);
      cfg_cycle = 20'($urandom);
      cfg_pulse = 12'($urandom);
      cfg_delay = 16'($urandom);
      cfg_gate  = 16'($urandom);
      step();
      check({name, "_first_pulse"}, tx_pulse, 1);
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      to = nexp * (v.exp_period + 5) + 20;
      while (!frame_done && to > 0) begin
         step();
         to--;
      end
      check({name, "_frame_in_time"}, int'(to > 0), 1);
      check({name, "_busy_at_frame"}, busy, 0);
      check({name, "_overrun"}, overrun, v.exp_overrun);
      check({name, "_frame_tick"}, cyc - last_shot, v.exp_period - 1);
      repeat (3) step();
      check({name, "_frame_count"}, frames, 1);
      check({name, "_all_shots"}, sb.size(), 0);
      check({name, "_idle_after"}, busy, 0);
      $display("[TB] %s: %0d shots expected, frame ended at cycle %0d", name, nexp, cyc);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int   to;
      bit   any;
      rec_t r;
      tests      = 0;
      failed     = 0;
      cyc        = 0;
      last_shot  = 0;
      frames     = 0;
      mon_en     = 1'b0;
      pulse_prev = 1'b0;
      gate_prev  = 1'b0;
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      cont       = 1'b0;
      buf_ready  = 1'b0;
      cfg_cycle  = '0;
      cfg_pulse  = '0;
      cfg_delay  = '0;
      cfg_gate   = '0;
      cfg_shots  = '0;
      cfg_mask   = '0;

      //           mask     shots  cycle    pulse   delay   gate   period goff pw ovr
      tbl[0] = '{4'b0101, 8'd2, 20'd100, 12'd10, 16'd20, 16'd30, 101, 30, 10, 1'b0};
      tbl[1] = '{4'b0001, 8'd2, 20'd40,  12'd10, 16'd20, 16'd30, 61,  30, 10, 1'b1};
      tbl[2] = '{4'b1010, 8'd1, 20'd20,  12'd0,  16'd0,  16'd0,  21,  1,  1,  1'b0};
      tbl[3] = '{4'b1111, 8'd0, 20'd30,  12'd5,  16'd0,  16'd10, 31,  5,  5,  1'b0};
      tbl[4] = '{4'b0100, 8'd3, 20'd30,  12'd10, 16'd10, 16'd10, 31,  20, 10, 1'b0};
      tbl[5] = '{4'b1000, 8'd2, 20'd31,  12'd10, 16'd10, 16'd10, 32,  20, 10, 1'b0};
      tbl[6] = '{4'b0001, 8'd2, 20'd29,  12'd10, 16'd10, 16'd10, 31,  20, 10, 1'b1};

      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_tx_pulse", tx_pulse, 0);
      check("rst_gate", gate, 0);
      check("rst_shot_start", shot_start, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_tx_ch", tx_ch, 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // start with an empty mask is ignored
      cfg_mask = 4'b0000;
      start    = 1'b1;
      step();
      start = 1'b0;
      check("mask0_busy", busy, 0);
      step();
      check("mask0_no_pulse", tx_pulse, 0);
      $display("[TB] mask0 start checked at cycle %0d", cyc);

      // start and abort together in IDLE: abort wins
      cfg_mask = 4'b0001;
      start    = 1'b1;
      abort    = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", busy, 0);
      step();
      check("start_abort_idle", busy, 0);
      $display("[TB] start+abort checked at cycle %0d", cyc);

      // capture buffer not ready: stay in ARM, fire one tick after it rises
      sb.delete();
      cfg_mask  = 4'b0001;
      cfg_shots = 8'd1;
      cfg_cycle = 20'd20;
      cfg_pulse = 12'd3;
      cfg_delay = 16'd2;
      cfg_gate  = 16'd2;
      buf_ready = 1'b0;
      r.ch = 2'd0; r.period = 0; r.gate_off = 5; r.pulse_w = 3;
      sb.push_back(r);
      frames = 0;
      mon_en = 1'b1;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("stall_busy", busy, 1);
      any = 1'b0;
      for (int k = 0; k < 50; k++) begin
         step();
         if (tx_pulse) any = 1'b1;
      end
      check("stall_no_pulse", any, 0);
      buf_ready = 1'b1;
      step();
      check("stall_fire", tx_pulse, 1);
      check("stall_shot_start", shot_start, 1);
      to = 60;
      while (!frame_done && to > 0) begin
         step();
         to--;
      end
      check("stall_frame_in_time", int'(to > 0), 1);
      check("stall_busy_at_frame", busy, 0);
      $display("[TB] buffer stall checked at cycle %0d", cyc);

      // continuous mode on a single channel, then abort mid-pulse
      sb.delete();
      cfg_mask  = 4'b1000;
      cfg_shots = 8'd1;
      cfg_cycle = 20'd25;
      cfg_pulse = 12'd4;
      cfg_delay = 16'd3;
      cfg_gate  = 16'd5;
      cont      = 1'b1;
      for (int k = 0; k < 4; k++) begin
         r.ch = 2'd3; r.period = (k == 0) ? 0 : 26; r.gate_off = 7; r.pulse_w = 4;
         sb.push_back(r);
      end
      mon_en = 1'b1;
      start  = 1'b1;
      step();
      start = 1'b0;
      cont  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         to = 100;
         while (!frame_done && to > 0) begin
            step();
            to--;
         end
         check("cont_frame_in_time", int'(to > 0), 1);
         check("cont_busy", busy, 1);
         check("cont_ch", tx_ch, 3);
         check("cont_frame_tick", cyc - last_shot, 25);
         step();
      end
      to = 100;
      while (!shot_start && to > 0) begin
         step();
         to--;
      end
      check("cont_next_shot", int'(to > 0), 1);
      mon_en = 1'b0;
      abort  = 1'b1;
      step();
      abort = 1'b0;
      check("abort_tx_pulse", tx_pulse, 0);
      check("abort_busy", busy, 0);
      check("abort_ch_hold", tx_ch, 3);
      check("abort_scoreboard", sb.size(), 0);
      step();
      check("abort_stays_idle", busy, 0);
      sb.delete();
      $display("[TB] continuous/abort checked at cycle %0d", cyc);

      // asynchronous reset in the middle of a gate window
      cfg_mask  = 4'b0100;
      cfg_shots = 8'd1;
      cfg_cycle = 20'd100;
      cfg_pulse = 12'd5;
      cfg_delay = 16'd5;
      cfg_gate  = 16'd40;
      buf_ready = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      to = 100;
      while (!gate && to > 0) begin
         step();
         to--;
      end
      check("rstg_reach_gate", int'(to > 0), 1);
      check("rstg_ch_before", tx_ch, 2);
      rst_n = 1'b0;
      #1;
      check("rstg_gate", gate, 0);
      check("rstg_busy", busy, 0);
      check("rstg_tx_pulse", tx_pulse, 0);
      check("rstg_tx_ch", tx_ch, 0);
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check("rstg_idle", busy, 0);
      $display("[TB] reset mid-gate checked at cycle %0d", cyc);
      run_vec(tbl[3], "after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Shot scheduler for the ultrasonic transmit path. It drives a multi-channel pulser and the acquisition front end. For each enabled channel it fires a configurable number of transmit pulses at a fixed repetition period. After each pulse it opens an acquisition gate at a programmed delay, and it waits for the capture buffer before every shot. It sits between the host register block and the pulser/ADC-capture logic, and is clocked by the 100 MHz system clock (1 tick = 10 ns).

## Interface
- NCH, 4, number of transmit channels (≥2); CW = clog2(NCH)
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-tick request to begin a scan; honoured only in IDLE with cfg_mask≠0
- abort  in  1  stops the scan; highest priority
- cont  in  1  latched at start; 1 = repeat frames until abort
- cfg_cycle  in  20  shot period in ticks; latched at start
- cfg_pulse  in  12  transmit pulse width in ticks; 0 is treated as 1
- cfg_delay  in  16  ticks from pulse end to gate open; 0 is allowed
- cfg_gate  in  16  gate width in ticks; 0 is treated as 1
- cfg_shots  in  8  shots per channel; 0 is treated as 1
- cfg_mask  in  NCH  channel enable mask
- buf_ready  in  1  capture buffer can accept one record
- busy  out  1  scan in progress
- tx_pulse  out  1  transmit pulse to the pulser
- tx_ch  out  CW  channel currently selected
- gate  out  1  acquisition window
- shot_start  out  1  one-tick strobe on the first tick of tx_pulse
- frame_done  out  1  one-tick strobe when all enabled channels are finished
- overrun  out  1  sticky flag: pulse+delay+gate > cycle; cleared on start

## Operation
- States: IDLE, ARM, FIRE, DELAY, GATE, HOLD.
- All cfg_* inputs and cont are captured into shadow registers when start is accepted. Later changes have no effect until the next start.
- IDLE → ARM on an accepted start.
  - tx_ch loads the lowest set bit of cfg_mask.
  - The shot counter clears and overrun clears.
- ARM: stays while buf_ready=0 (no timeout). When buf_ready=1, go to FIRE on the next tick.
- FIRE: tx_pulse=1 for exactly pulse ticks.
  - The period counter pcnt = 1 on the first FIRE tick and increments every tick through HOLD.
  - Then go to DELAY, or straight to GATE if delay=0.
- DELAY: lasts delay ticks. GATE: gate=1 for gate ticks. Then HOLD.
- HOLD: leave when pcnt ≥ cycle; if already satisfied on entry, leave after 1 tick.
  - On entry to HOLD, if pcnt−1 > cycle, set overrun. The period then stretches; shots never overlap.
- On leaving HOLD:
  - If shot count+1 < shots: increment the count and go to ARM on the same channel.
  - Otherwise clear the count and advance tx_ch to the next set mask bit above the current one, then go to ARM.
  - If there is no higher set bit, the frame ends: pulse frame_done. If cont=1, go to ARM with tx_ch set to the lowest set bit; otherwise go to IDLE.
- abort in any state: next tick is IDLE with tx_pulse=gate=busy=0. tx_ch holds its value; overrun holds.
- start while busy is ignored. start with cfg_mask=0 is ignored.
- Simultaneous start and abort in IDLE: abort wins and the state stays IDLE.
- Counter widths: pcnt is 21 bits and saturates at all-ones. pulse/delay/gate counters are 16 bits.

## Timing
- Reset values: busy=0, tx_pulse=0, gate=0, shot_start=0, frame_done=0, overrun=0, tx_ch=0, state IDLE.
- All outputs are registered.
- start at tick T (buf_ready=1) → busy=1 at T+1 (ARM) → tx_pulse=1 and shot_start=1 at T+2.
- Shot-to-shot period with buf_ready held high = max(cycle, pulse+delay+gate) + 1 ticks (the +1 is the ARM tick).
- gate rises exactly pulse+delay ticks after tx_pulse rises.
- frame_done is asserted on the first tick after the final HOLD. busy falls on that same tick when cont=0.
- tx_ch changes only on the ARM-entry tick, never while tx_pulse or gate is high.

## Test plan
- Reset mid-GATE (rst_n low 3 ticks): all outputs go 0 immediately and asynchronously. After release, state is IDLE and start behaves normally.
- mask=4'b0101, shots=2, cycle=100, pulse=10, delay=20, gate=30, buf_ready=1, cont=0:
  - 4 shot_start strobes, 101 ticks apart, with tx_ch sequence 0,0,2,2.
  - gate rises 30 ticks after each tx_pulse rise.
  - 1 frame_done; busy falls on the frame_done tick; overrun=0.
- cycle=40, pulse=10, delay=20, gate=30: overrun=1 after the first shot; period 61 ticks; no overlap of tx_pulse with gate.
- buf_ready low for 50 ticks in ARM: tx_pulse stays 0. It fires exactly 1 tick after buf_ready rises.
- cont=1, mask=4'b1000, shots=1: frame_done every period, tx_ch stays 3. abort during FIRE drops tx_pulse and busy the next tick.
- Boundary values:
  - pulse=0 gives a 1-tick pulse.
  - delay=0 makes gate rise directly after tx_pulse falls.
  - start with mask=0 is ignored.
  - start while busy is ignored.
